// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: one registered issue stage feeding an external combinational ALU.
// Results are captured into a small in-order response FIFO.
module alu_issue_seq #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RSP_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_y,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      done_cnt
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RSP_DEPTH - 1);
  localparam logic [OccW-1:0] DepthOcc = OccW'(RSP_DEPTH);

  logic             issue_v_q, issue_v_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  // Response storage is left unreset; it is only visible while count_q != 0.
  logic [31:0]      mem_y_q     [RSP_DEPTH];
  logic [3:0]       mem_flags_q [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag_q   [RSP_DEPTH];

  logic [OccW-1:0] occ;
  logic            accept;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // The issue stage reserves a FIFO slot, so ready looks at count plus issue_v.
  always_comb begin
    occ       = {1'b0, count_q} + OccW'(issue_v_q);
    req_ready = rst_n & ~flush & (occ < DepthOcc);
    accept    = req_valid & req_ready;
    push      = issue_v_q & ~flush;
    pop       = (count_q != '0) & rsp_ready;
  end

  always_comb begin
    issue_v_d   = issue_v_q;
    issue_tag_d = issue_tag_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    done_cnt_d  = done_cnt_q + {15'd0, pop};

    if (accept) begin
      alu_a_d     = req_a;
      alu_b_d     = req_b;
      alu_op_d    = req_op;
      issue_tag_d = req_tag;
    end

    if (flush) begin
      issue_v_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (accept) begin
        issue_v_d = 1'b1;
      end else if (push) begin
        issue_v_d = 1'b0;
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v_q   <= 1'b0;
      issue_tag_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_cnt_q  <= '0;
    end else begin
      issue_v_q   <= issue_v_d;
      issue_tag_q <= issue_tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_y_q[wr_ptr_q]     <= alu_y;
      mem_flags_q[wr_ptr_q] <= alu_flags;
      mem_tag_q[wr_ptr_q]   <= issue_tag_q;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = (count_q != '0);
  assign rsp_y     = mem_y_q[rd_ptr_q];
  assign rsp_flags = mem_flags_q[rd_ptr_q];
  assign rsp_tag   = mem_tag_q[rd_ptr_q];
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: directed vectors, scoreboard queue checked by a negedge monitor.
module tb_alu_issue_seq;

  localparam int unsigned TagW = 4;

  typedef struct packed {
    logic [31:0]     y;
    logic [3:0]      flags;
    logic [TagW-1:0] tag;
  } rsp_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [3:0]      req_op;
  logic [TagW-1:0] req_tag;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [3:0]      alu_op;
  logic [31:0]     alu_y;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_y;
  logic [3:0]      rsp_flags;
  logic [TagW-1:0] rsp_tag;
  logic [15:0]     done_cnt;

  alu_issue_seq #(
    .TAG_W    (TagW),
    .RSP_DEPTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .req_tag  (req_tag),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_flags(alu_flags),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_y    (rsp_y),
    .rsp_flags(rsp_flags),
    .rsp_tag  (rsp_tag),
    .done_cnt (done_cnt)
  );

  // Stand-in ALU core: op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; flags = {Z, N, 0, 0}.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'd0: alu_y = alu_a + alu_b;
      4'd1: alu_y = alu_a - alu_b;
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      4'd4: alu_y = alu_a ^ alu_b;
      default: alu_y = '0;
    endcase
    alu_flags = {(alu_y == 32'd0), alu_y[31], 2'b00};
  end

  // Directed vectors with hand-computed results.
  logic [3:0]  vec_op [9] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd0, 4'd0};
  logic [31:0] vec_a  [9] = '{32'd1, 32'd10, 32'd3, 32'h0000_F0F0, 32'h0000_000F,
                              32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd5};
  logic [31:0] vec_b  [9] = '{32'd2, 32'd3, 32'd3, 32'h0000_FF00, 32'h0000_00F0,
                              32'h0000_0001, 32'd1, 32'h8000_0000, 32'd7};
  logic [31:0] vec_y  [9] = '{32'd3, 32'd7, 32'd0, 32'h0000_F000, 32'h0000_00FF,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd12};
  logic [3:0]  vec_f  [9] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h4, 4'h4, 4'h8, 4'h0};

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_pop = -10;
  int   run      = 0;
  int   max_run  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop is compared against the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rsp: got tag %0h expected no response", rsp_tag);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
      end
      run      = (last_pop == cyc - 1) ? run + 1 : 1;
      max_run  = (run > max_run) ? run : max_run;
      last_pop = cyc;
    end
  end

  task automatic set_req(input int v, input logic [TagW-1:0] tag);
    req_a   = vec_a[v];
    req_b   = vec_b[v];
    req_op  = vec_op[v];
    req_tag = tag;
  endtask

  task automatic push_exp(input int v, input logic [TagW-1:0] tag);
    rsp_t e;
    e.y     = vec_y[v];
    e.flags = vec_f[v];
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic send(input int v, input logic [TagW-1:0] tag, output int waits);
    waits     = 0;
    req_valid = 1'b1;
    set_req(v, tag);
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (req_ready) push_exp(v, tag);
    else chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int w;
    int tot;
    int acc;
    int k;
    logic [15:0] base;
    logic seen;

    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single ADD: 5 + 7, tag 3
    send(8, 4'd3, w);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_early_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_rsp_y", rsp_y, 32'd12);
    chk("add_rsp_tag", {28'd0, rsp_tag}, 32'd3);
    drain();
    chk("add_done_cnt", {16'd0, done_cnt}, 32'd1);

    // Streaming: 8 back-to-back, tags 0..7
    base    = done_cnt;
    max_run = 0;
    tot     = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(i, TagW'(i), w);
      tot += w;
    end
    chk("stream_ready_stalls", tot, 32'd0);
    drain();
    chk("stream_done_delta", {16'd0, done_cnt - base}, 32'd8);
    chk("stream_consecutive", {31'd0, max_run >= 8}, 32'd1);

    // Backpressure: continuous requests with rsp_ready low
    rsp_ready = 1'b0;
    base      = done_cnt;
    acc       = 0;
    k         = 0;
    req_valid = 1'b1;
    set_req(0, 4'd8);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready) begin
        push_exp(k, TagW'(8 + k));
        acc++;
        k++;
      end
      @(posedge clk);
      #1;
      set_req(k, TagW'(8 + k));
    end
    req_valid = 1'b0;
    chk("bp_accepts", acc, 32'd3);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_head_tag", {28'd0, rsp_tag}, 32'd8);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    drain();
    chk("bp_done_delta", {16'd0, done_cnt - base}, 32'd3);

    // Full push/pop: count=2, issue_v=1, rsp_ready=1 on one edge
    rsp_ready = 1'b0;
    base      = done_cnt;
    send(0, 4'd1, w);
    send(1, 4'd2, w);
    send(2, 4'd3, w);
    chk("pp_head_before", {28'd0, rsp_tag}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("pp_head_after", {28'd0, rsp_tag}, 32'd2);
    chk("pp_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("pp_hold_tag", {28'd0, rsp_tag}, 32'd2);
    chk("pp_hold_y", rsp_y, vec_y[1]);
    drain();
    chk("pp_done_delta", {16'd0, done_cnt - base}, 32'd3);

    // Flush with count=2, issue_v=1 and a pending request
    rsp_ready = 1'b0;
    send(3, 4'd4, w);
    send(4, 4'd5, w);
    send(5, 4'd6, w);
    base      = done_cnt;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'hDEAD_BEEF;
    req_op    = 4'd2;
    req_tag   = 4'd15;
    #1;
    chk("fl_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    chk("fl_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("fl_alu_a_held", alu_a, vec_a[5]);
    chk("fl_alu_op_held", {28'd0, alu_op}, {28'd0, vec_op[5]});
    chk("fl_done_cnt", {16'd0, done_cnt}, {16'd0, base});
    @(posedge clk);
    #1;
    chk("fl_no_push", {31'd0, rsp_valid}, 32'd0);

    // Asynchronous reset mid-stream
    rsp_ready = 1'b1;
    send(6, 4'd1, w);
    send(1, 4'd2, w);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_alu_op", {28'd0, alu_op}, 32'd0);
    chk("ar_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("ar_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("ar_no_spurious", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    send(8, 4'd9, w);
    drain();
    chk("ar_done_after", {16'd0, done_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
